// File: rtl/blink_multi.sv
// ---------------------------------------------------------------------------
// blink_multi -- multi-channel LED pattern generator
//
// A shared prescaler divides clk down to a one-cycle base tick. Every channel
// runs its own runtime-configured mode, advancing only on that tick:
//   OFF   : led held at 0
//   ON    : led held at 1
//   BLINK : led toggles every `half` ticks (full period 2*half ticks)
//   BURST : `burst` pulses of `half` ticks high / `half` ticks low, followed
//           by a gap of 4*half ticks low, repeating
//
// Optional build macro: BLINK_SYNC_EN
//   When defined, adds input sync_all. A 1 on sync_all restarts the prescaler
//   and every channel from its start point so all channels run phase-aligned.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous reset, active-high
//   sync_all   in   (BLINK_SYNC_EN only) restart every channel and the prescaler
//   cfg_we     in   config write strobe
//   cfg_ch     in   [CH_W]     target channel
//   cfg_mode   in   [2]        0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_half   in   [CNT_W]    half-period in ticks, 0 treated as 1
//   cfg_burst  in   [BURST_W]  pulses per burst, 0 treated as 1
//   cfg_ready  out             high when a write can be accepted
//   tick       out             one-cycle base tick pulse
//   led        out  [CHANNELS] LED drive, bit i = channel i
//
// All outputs come from registers; there is no combinational path from any
// input to any output.
// ---------------------------------------------------------------------------
module blink_multi #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 32,
  parameter int BURST_W  = 4,
  parameter int PRESCALE = 5
) (
  input  logic                clk,
  input  logic                rst,
`ifdef BLINK_SYNC_EN
  input  logic                sync_all,
`endif
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
  input  logic [BURST_W-1:0]  cfg_burst,
  output logic                cfg_ready,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  // -------------------------------------------------------------------------
  // Types
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PULSE_ON  = 2'd0,
    PULSE_OFF = 2'd1,
    GAP       = 2'd2
  } burst_state_e;

  // Complete per-channel state in one struct so a checker can bind to ch[i]
  // and see configuration, counters and burst FSM state together.
  typedef struct packed {
    mode_e              mode;
    logic [CNT_W-1:0]   half;   // effective half-period, never 0
    logic [BURST_W-1:0] burst;  // effective pulses per burst, never 0
    logic [CNT_W-1:0]   phase;  // ticks elapsed inside the current half period
    logic [BURST_W-1:0] pcnt;   // pulses completed in the current burst
    logic [1:0]         gap;    // half periods elapsed inside the gap
    burst_state_e       bst;    // burst FSM state
  } chan_t;

  localparam chan_t CHAN_RESET = '{
    mode:  MODE_OFF,
    half:  CNT_W'(1),
    burst: BURST_W'(1),
    phase: '0,
    pcnt:  '0,
    gap:   2'd0,
    bst:   PULSE_ON
  };

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PS_W-1:0]     presc;
  chan_t               ch [CHANNELS];

  logic                accept;
  logic                ch_valid;
  logic [CNT_W-1:0]    half_eff;
  logic [BURST_W-1:0]  burst_eff;
  logic [CHANNELS-1:0] phase_last;

  // Tick is a decode of the registered prescaler count, so it is high for
  // exactly the cycle in which the count sits at PRESCALE-1. With PRESCALE=1
  // the count never leaves 0 and the tick is permanently high.
  assign tick = (presc == PS_LAST);

  // Config handshake: a write is taken on a rising edge where cfg_we=1,
  // cfg_ready=1 and cfg_ch names an existing channel. cfg_ready is then low
  // for exactly one cycle; cfg_we seen while cfg_ready=0 is dropped, and a
  // write to a nonexistent channel is dropped without touching cfg_ready.
  assign ch_valid  = ({1'b0, cfg_ch} < CH_LIMIT);
  assign accept    = cfg_we && cfg_ready && ch_valid;
  assign half_eff  = (cfg_half  == '0) ? CNT_W'(1)   : cfg_half;
  assign burst_eff = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;

  // A channel's current half period ends on the tick where phase has
  // already reached half-1.
  always_comb begin
    phase_last = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      phase_last[i] = (ch[i].phase == (ch[i].half - CNT_W'(1)));
    end
  end

  // Output level a channel shows right after it is (re)started.
  function automatic logic start_level(input mode_e m);
    return (m == MODE_ON) || (m == MODE_BURST);
  endfunction

  // -------------------------------------------------------------------------
  // Prescaler, handshake and all channel FSMs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      cfg_ready <= 1'b1;
      led       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ch[i] <= CHAN_RESET;
      end
    end else begin
      cfg_ready <= !accept;
      presc     <= tick ? '0 : presc + PS_W'(1);

      for (int i = 0; i < CHANNELS; i++) begin
        if (accept && (cfg_ch == CH_W'(i))) begin
          // A write to this channel takes precedence over a same-cycle tick;
          // the tick is simply not applied to the freshly written channel.
          ch[i].mode  <= mode_e'(cfg_mode);
          ch[i].half  <= half_eff;
          ch[i].burst <= burst_eff;
          ch[i].phase <= '0;
          ch[i].pcnt  <= '0;
          ch[i].gap   <= 2'd0;
          ch[i].bst   <= PULSE_ON;
          led[i]      <= start_level(mode_e'(cfg_mode));
        end else if (tick) begin
          case (ch[i].mode)
            MODE_BLINK: begin
              if (phase_last[i]) begin
                ch[i].phase <= '0;
                led[i]      <= ~led[i];
              end else begin
                ch[i].phase <= ch[i].phase + CNT_W'(1);
              end
            end

            MODE_BURST: begin
              if (!phase_last[i]) begin
                ch[i].phase <= ch[i].phase + CNT_W'(1);
              end else begin
                ch[i].phase <= '0;
                case (ch[i].bst)
                  PULSE_ON: begin
                    ch[i].bst <= PULSE_OFF;
                    led[i]    <= 1'b0;
                  end

                  PULSE_OFF: begin
                    // burst is never 0, so burst-1 cannot wrap.
                    if (ch[i].pcnt == (ch[i].burst - BURST_W'(1))) begin
                      ch[i].pcnt <= '0;
                      ch[i].bst  <= GAP;
                    end else begin
                      ch[i].pcnt <= ch[i].pcnt + BURST_W'(1);
                      ch[i].bst  <= PULSE_ON;
                      led[i]     <= 1'b1;
                    end
                  end

                  GAP: begin
                    // Gap length is 4 half periods, counted by the 2-bit
                    // sub-counter; its wrap to 0 coincides with the exit.
                    ch[i].gap <= ch[i].gap + 2'd1;
                    if (ch[i].gap == 2'd3) begin
                      ch[i].bst <= PULSE_ON;
                      led[i]    <= 1'b1;
                    end
                  end

                  default: begin
                    ch[i].bst <= PULSE_ON;
                    led[i]    <= 1'b1;
                  end
                endcase
              end
            end

            default: begin
              // OFF and ON hold their level; ticks are ignored.
            end
          endcase
        end
      end

`ifdef BLINK_SYNC_EN
      // Restart everything from a common origin. These assignments come last
      // so they override any tick update above. A same-cycle config write
      // has already latched its mode/half/burst, so the restart uses the new
      // mode for that channel.
      if (sync_all) begin
        presc <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          ch[i].phase <= '0;
          ch[i].pcnt  <= '0;
          ch[i].gap   <= 2'd0;
          ch[i].bst   <= PULSE_ON;
          if (accept && (cfg_ch == CH_W'(i))) begin
            led[i] <= start_level(mode_e'(cfg_mode));
          end else begin
            led[i] <= start_level(ch[i].mode);
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_blink_multi.sv
// ---------------------------------------------------------------------------
// tb_blink_multi -- self-checking bench for blink_multi
//
// The reference model tracks, per channel, only the configuration and the
// number of ticks applied since the channel was last (re)started. The LED
// level is then derived arithmetically from that tick count:
//   BLINK : (t / half) odd
//   BURST : position inside a period of 2*half*burst + 4*half ticks
// Every cycle the expected {cfg_ready, tick, led} is pushed to exp_q before
// the clock edge and popped/compared on the following falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_blink_multi;

  localparam int CHANNELS = 4;
  localparam int CH_W     = 3;
  localparam int CNT_W    = 32;
  localparam int BURST_W  = 4;
  localparam int PRESCALE = 5;
  localparam int EW       = CHANNELS + 2;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT
  // -------------------------------------------------------------------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_we = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [1:0]          cfg_mode = '0;
  logic [CNT_W-1:0]    cfg_half = '0;
  logic [BURST_W-1:0]  cfg_burst = '0;
  logic                cfg_ready;
  logic                tick;
  logic [CHANNELS-1:0] led;
`ifdef BLINK_SYNC_EN
  logic                sync_all = 1'b0;
`endif

  always #5 clk = ~clk;

  blink_multi #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W),
    .CNT_W    (CNT_W),
    .BURST_W  (BURST_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BLINK_SYNC_EN
    .sync_all  (sync_all),
`endif
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_burst (cfg_burst),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .led       (led)
  );

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int  m_presc;
  bit  m_ready;
  int  m_mode  [CHANNELS];
  int  m_half  [CHANNELS];
  int  m_burst [CHANNELS];
  int  m_t     [CHANNELS];

  logic [EW-1:0] exp_q [$];
  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  function automatic void model_reset();
    m_presc = 0;
    m_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      m_mode[i]  = 0;
      m_half[i]  = 1;
      m_burst[i] = 1;
      m_t[i]     = 0;
    end
  endfunction

  function automatic bit model_led(int i);
    int h;
    int b;
    int p;
    h = m_half[i];
    b = m_burst[i];
    case (m_mode[i])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((m_t[i] / h) % 2) == 1;
      default: begin
        p = m_t[i] % (2 * h * b + 4 * h);
        if (p < 2 * h * b) return ((p / h) % 2) == 0;
        return 1'b0;
      end
    endcase
  endfunction

  function automatic void model_step(bit r, bit s, bit we, int c, int mode, int half, int burst);
    bit tk;
    bit acc;
    if (r) begin
      model_reset();
      return;
    end
    tk  = (m_presc == PRESCALE - 1);
    acc = we && m_ready && (c < CHANNELS);
    for (int i = 0; i < CHANNELS; i++) begin
      if (acc && (c == i)) begin
        m_mode[i]  = mode;
        m_half[i]  = (half  == 0) ? 1 : half;
        m_burst[i] = (burst == 0) ? 1 : burst;
        m_t[i]     = 0;
      end else if (tk) begin
        m_t[i]++;
      end
    end
    m_presc = tk ? 0 : m_presc + 1;
    m_ready = !acc;
    if (s) begin
      m_presc = 0;
      for (int i = 0; i < CHANNELS; i++) m_t[i] = 0;
    end
  endfunction

  function automatic logic [EW-1:0] exp_vec();
    logic [CHANNELS-1:0] l;
    l = '0;
    for (int i = 0; i < CHANNELS; i++) l[i] = model_led(i);
    return {m_ready, (m_presc == PRESCALE - 1), l};
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    assert (got === want)
    else begin
      tests_failed++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check("led",       32'(led),       32'(e[CHANNELS-1:0]));
    check("tick",      32'(tick),      32'(e[CHANNELS]));
    check("cfg_ready", 32'(cfg_ready), 32'(e[CHANNELS+1]));
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (called just after a falling edge)
  // -------------------------------------------------------------------------
  task automatic cycle(input bit r, input bit s, input bit we, input int c,
                       input int mode, input int half, input int burst);
    rst       = r;
    cfg_we    = we;
    cfg_ch    = CH_W'(c);
    cfg_mode  = 2'(mode);
    cfg_half  = CNT_W'(half);
    cfg_burst = BURST_W'(burst);
`ifdef BLINK_SYNC_EN
    sync_all  = s;
`endif
    model_step(r, s, we, c, mode, half, burst);
    exp_q.push_back(exp_vec());
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int c, input int mode, input int half, input int burst);
    cycle(1'b0, 1'b0, 1'b1, c, mode, half, burst);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Directed + randomized sequence
  // -------------------------------------------------------------------------
  initial begin
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset();
    do_reset();
    check("reset_led_const", 32'(led), 32'(0));
    check("reset_ready_const", 32'(cfg_ready), 32'(1));

    // Idle: tick every PRESCALE cycles, LEDs dark
    repeat (20) idle();
    check("idle_led_const", 32'(led), 32'(0));

    // ch1 BLINK half=2
    wr(1, 2, 2, 1);
    check("blink_start_const", 32'(led[1]), 32'(0));
    check("ready_drop_const", 32'(cfg_ready), 32'(0));
    repeat (45) idle();

    // ch2 BURST half=1 burst=3
    wr(2, 3, 1, 3);
    check("burst_start_const", 32'(led[2]), 32'(1));
    repeat (60) idle();

    // Back-to-back writes: second one (ch3 ON) must be dropped
    wr(3, 0, 1, 1);
    wr(3, 1, 1, 1);
    check("b2b_ignored_const", 32'(led[3]), 32'(0));
    idle();

    // Nonexistent channel: no effect, cfg_ready stays high
    wr(4, 1, 1, 1);
    check("bad_ch_ready_const", 32'(cfg_ready), 32'(1));
    idle();

    // Write coincident with a tick wins over the tick
    wr(0, 2, 1, 1);
    for (int k = 0; k < PRESCALE && m_presc != PRESCALE - 1; k++) idle();
    wr(0, 1, 1, 1);
    check("write_wins_const", 32'(led[0]), 32'(1));
    repeat (8) idle();

    // Randomized configuration traffic, including out-of-range channels,
    // zero half/burst and writes while cfg_ready is low
    repeat (600) begin
      bit s;
      s = 1'b0;
`ifdef BLINK_SYNC_EN
      s = ($urandom_range(0, 59) == 0);
`endif
      cycle(1'b0, s, ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a burst
    wr(2, 3, 2, 2);
    repeat (13) idle();
    do_reset();
    check("midburst_reset_const", 32'(led), 32'(0));
    repeat (12) idle();
    check("after_reset_off_const", 32'(led), 32'(0));

`ifdef BLINK_SYNC_EN
    // Two BLINK channels started 7 cycles apart, then realigned
    wr(0, 2, 3, 1);
    repeat (6) idle();
    wr(3, 2, 3, 1);
    repeat (9) idle();
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      idle();
      check("sync_aligned", 32'(led[3]), 32'(model_led(0)));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/blink_multi.md
Name: blink_multi

Overview:
Multi-channel LED pattern generator. It is the parametrised successor of the single-channel fixed-rate blinker. One shared prescaler produces a base tick. Each of CHANNELS outputs runs its own runtime-configured mode (OFF / ON / BLINK / BURST) with a programmable half-period and burst count. Sits between the board clock and the status LEDs; configured by a simple write-strobe interface from control logic.

Parameters:
CHANNELS, 4, number of LED outputs (1..2**CH_W).
CH_W, 2, width of channel select.
CNT_W, 32, width of half-period register and phase counters.
BURST_W, 4, width of burst-count register.
PRESCALE, 5, clk cycles per base tick (>=1).

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous reset, active-high.
cfg_we  in  1  config write strobe; accepted only when cfg_ready=1.
cfg_ch  in  CH_W  target channel.
cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
cfg_half  in  CNT_W  half-period in ticks; 0 treated as 1.
cfg_burst  in  BURST_W  pulses per burst; 0 treated as 1.
cfg_ready  out  1  high when a write can be accepted.
tick  out  1  one-cycle base tick pulse.
led  out  CHANNELS  LED drive, bit i = channel i.

Behaviour:
- Reset (rst=1 at posedge): prescaler=0, tick=0, cfg_ready=1, led=0. All modes=OFF, half=1, burst=1. All phase/burst/gap counters=0, burst FSM=PULSE_ON.
- Prescaler: counts 0..PRESCALE-1. tick=1 for exactly the cycle in which the count equals PRESCALE-1, then the count wraps to 0. With PRESCALE=1, tick is constantly 1.
- Config handshake:
  - Write accepted when cfg_we=1 and cfg_ready=1 and cfg_ch<CHANNELS.
  - On accept, mode, half and burst are latched into the channel. Its counters clear and its FSM goes to PULSE_ON.
  - cfg_ready drops to 0 for exactly the next cycle after an accept. cfg_we while cfg_ready=0 is ignored.
  - Write with cfg_ch>=CHANNELS: ignored, cfg_ready unaffected.
- Channel output on accept, registered (visible the cycle after accept): OFF->0, ON->1, BLINK->0, BURST->1.
- OFF/ON: led constant, ticks ignored.
- BLINK: on each tick, phase++. When phase reaches half-1, led toggles and phase goes to 0. Full period = 2*half ticks.
- BURST FSM, states PULSE_ON, PULSE_OFF, GAP; all advance only on tick:
  - PULSE_ON (led=1): after half ticks -> PULSE_OFF.
  - PULSE_OFF (led=0): after half ticks, pulse count++. If count==burst -> GAP (count cleared), else -> PULSE_ON.
  - GAP (led=0): after 4*half ticks -> PULSE_ON. The gap uses a 2-bit sub-counter over half periods; no wider arithmetic.
- Simultaneous tick and accepted write to the same channel: write wins, and that tick is not applied to that channel. Other channels advance normally.
- led only changes on tick or accepted write; no combinational paths from inputs to outputs.
- Reset mid-pattern: next-cycle state identical to post-reset state.

Optional Feature:
BLINK_SYNC_EN. When defined, the block adds input port sync_all (1 bit). A 1 on sync_all clears the prescaler and every channel's counters, resets BURST channels to PULSE_ON, and re-applies the per-mode start value to led. All channels then run phase-aligned. sync_all has priority over cfg writes in the same cycle; the write is still accepted and cfg_ready still drops. When not defined, the port is absent and the block does not implement this behaviour.

Test Plan:
- Reset, then no writes for 20 cycles -> led=0000. tick high at cycles 5, 10, 15, 20 after rst release (PRESCALE=5). cfg_ready=1.
- Write ch1 BLINK half=2 -> led[1]=0 after accept, then toggles every 10 clk cycles (period 20). Other bits stay 0.
- Write ch2 BURST half=1 burst=3 -> led[2] pattern per tick: 1,0,1,0,1,0,0,0,0,0, repeating every 10 ticks (50 cycles).
- Two cfg_we on consecutive cycles -> first accepted, cfg_ready=0 next cycle, second ignored. Write to cfg_ch=4 with CH_W=3, CHANNELS=4 -> no change.
- Write ch0 ON coincident with tick while ch0 is in BLINK -> led[0]=1 next cycle. Assert rst mid-BURST -> led=0, modes OFF next cycle.
- BLINK_SYNC_EN defined: ch0 and ch3 both BLINK half=3 started 7 cycles apart, pulse sync_all -> both toggle on the same cycle thereafter.
